// File: rtl/matrix_scan_if.sv
// Board-in / LED-out signal bundle for the row-scanned dot-matrix driver.
// master = board source side, slave = the scan driver.
interface matrix_scan_if;
   logic [63:0] mat;
   logic        mat_load;
   logic [7:0]  row_sel;
   logic [7:0]  col_out;
   logic        frame_done;
   logic        busy_pending;

   modport master (
      output mat, mat_load,
      input  row_sel, col_out, frame_done, busy_pending
   );

   modport slave (
      input  mat, mat_load,
      output row_sel, col_out, frame_done, busy_pending
   );
endinterface

// File: rtl/matrix_scan.sv
// Row-multiplexed 8x8 LED driver: one row per DWELL cycles, first BLANK cycles dark.
// Boards are double-buffered and swapped only at the frame boundary; mat_load is never back-pressured.
module matrix_scan #(
   parameter int unsigned DWELL = 5000,
   parameter int unsigned BLANK = 2
) (
   input  logic          clk,
   input  logic          rst,
   matrix_scan_if.slave  bus
);
   localparam logic [15:0] DWELL_M1 = 16'(DWELL - 1);

   logic [2:0]  row_idx_q, row_idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [63:0] staging_q, staging_d;
   logic [63:0] shadow_q, shadow_d;
   logic        pending_q, pending_d;
   logic        frame_done_q, frame_done_d;
   logic        row_end;
   logic        boundary;
   logic        lit;
   logic [7:0]  cur_row;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_idx_q    <= '0;
         cnt_q        <= '0;
         staging_q    <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         row_idx_q    <= row_idx_d;
         cnt_q        <= cnt_d;
         staging_q    <= staging_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      row_idx_d = row_idx_q;
      cnt_d     = cnt_q + 16'd1;
      staging_d = staging_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      row_end   = (cnt_q == DWELL_M1);
      boundary  = row_end && (row_idx_q == 3'd7);

      if (row_end) begin
         cnt_d     = '0;
         row_idx_d = row_idx_q + 3'd1;
      end

      if (bus.mat_load) begin
         staging_d = bus.mat;
         pending_d = 1'b1;
      end

      // A load landing on the boundary itself bypasses staging straight into the next frame.
      if (boundary) begin
         if (bus.mat_load) begin
            shadow_d  = bus.mat;
            pending_d = 1'b0;
         end else if (pending_q) begin
            shadow_d  = staging_q;
            pending_d = 1'b0;
         end
      end

      frame_done_d = boundary;
   end

   generate
      if (BLANK == 0) begin : g_no_blank
         assign lit = 1'b1;
      end else begin : g_blank
         assign lit = (cnt_q >= 16'(BLANK));
      end
   endgenerate

   // Row r lives at bits 63-8r down to 56-8r; {~r, 3'b111} is exactly 63-8r.
   assign cur_row = shadow_q[{~row_idx_q, 3'b111} -: 8];

   assign bus.row_sel      = 8'b1 << row_idx_q;
   assign bus.col_out      = lit ? cur_row : 8'h00;
   assign bus.frame_done   = frame_done_q;
   assign bus.busy_pending = pending_q;
endmodule

// File: tb/tb_matrix_scan.sv
// Scoreboard bench for matrix_scan: two instances (BLANK=1 and BLANK=3, DWELL=4).
module tb_matrix_scan;
   localparam int DW = 4;
   localparam int FR = 8 * DW;

   typedef struct {
      int         t;
      logic [7:0] rs;
      logic [7:0] cs;
      logic       fd;
      logic       bp;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   sel;
   bit   mon_en;
   exp_t exp_q[$];
   exp_t e;
   int          ld_cyc[$];
   logic [63:0] ld_mat[$];

   matrix_scan_if if0();
   matrix_scan_if if1();

   matrix_scan #(.DWELL(DW), .BLANK(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   matrix_scan #(.DWELL(DW), .BLANK(3)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Closed-form expectation for cycle t after reset release, from the recorded load list.
   task automatic model(input int t, input int blank, output exp_t x);
      int          f;
      int          r;
      int          c;
      int          b;
      logic [63:0] board;
      f     = t / FR;
      r     = (t % FR) / DW;
      c     = t % DW;
      board = '0;
      x.bp  = 1'b0;
      for (int i = 0; i < ld_cyc.size(); i++) begin
         if (f >= 1 && ld_cyc[i] <= FR * f - 1) board = ld_mat[i];
         b = FR * (ld_cyc[i] / FR + 1) - 1;
         if (ld_cyc[i] < t && ld_cyc[i] != b && t <= b) x.bp = 1'b1;
      end
      x.t  = t;
      x.rs = 8'(1 << r);
      x.cs = (c < blank) ? 8'h00 : board[63 - 8 * r -: 8];
      x.fd = (t > 0) && (t % FR == 0);
   endtask

   task automatic drive(input logic ld, input logic [63:0] m);
      if0.mat_load = 1'b0;
      if1.mat_load = 1'b0;
      if0.mat      = '0;
      if1.mat      = '0;
      if (sel == 0) begin
         if0.mat_load = ld;
         if0.mat      = m;
      end else begin
         if1.mat_load = ld;
         if1.mat      = m;
      end
   endtask

   task automatic check_reset(input string tag);
      logic [7:0] rs;
      logic [7:0] cs;
      logic       fd;
      logic       bp;
      rs = (sel == 0) ? if0.row_sel      : if1.row_sel;
      cs = (sel == 0) ? if0.col_out      : if1.col_out;
      fd = (sel == 0) ? if0.frame_done   : if1.frame_done;
      bp = (sel == 0) ? if0.busy_pending : if1.busy_pending;
      check({tag, "_row_sel"}, 64'(rs), 64'h01);
      check({tag, "_col_out"}, 64'(cs), 64'h00);
      check({tag, "_frame_done"}, 64'(fd), 64'h0);
      check({tag, "_busy_pending"}, 64'(bp), 64'h0);
   endtask

   task automatic run(input int s, input int n);
      exp_t x;
      logic        ld;
      logic [63:0] m;
      sel = s;
      drive(1'b0, '0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset("rst");
      rst    = 1'b1;
      mon_en = 1'b1;
      for (int t = 0; t < n; t++) begin
         ld = 1'b0;
         m  = '0;
         for (int i = 0; i < ld_cyc.size(); i++) begin
            if (ld_cyc[i] == t) begin
               ld = 1'b1;
               m  = ld_mat[i];
            end
         end
         drive(ld, m);
         model(t, (sel == 0) ? 1 : 3, x);
         exp_q.push_back(x);
         @(posedge clk);
         #1;
      end
      mon_en = 1'b0;
      drive(1'b0, '0);
   endtask

   task automatic add_load(input int c, input logic [63:0] m);
      ld_cyc.push_back(c);
      ld_mat.push_back(m);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 64'h1, 64'h0);
         end else begin
            logic [7:0] rs;
            logic [7:0] cs;
            logic       fd;
            logic       bp;
            e  = exp_q.pop_front();
            rs = (sel == 0) ? if0.row_sel      : if1.row_sel;
            cs = (sel == 0) ? if0.col_out      : if1.col_out;
            fd = (sel == 0) ? if0.frame_done   : if1.frame_done;
            bp = (sel == 0) ? if0.busy_pending : if1.busy_pending;
            check($sformatf("row_sel@%0d", e.t), 64'(rs), 64'(e.rs));
            check($sformatf("col_out@%0d", e.t), 64'(cs), 64'(e.cs));
            check($sformatf("frame_done@%0d", e.t), 64'(fd), 64'(e.fd));
            check($sformatf("busy_pending@%0d", e.t), 64'(bp), 64'(e.bp));
            check($sformatf("onehot@%0d", e.t), 64'($onehot(rs)), 64'h1);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      mon_en   = 1'b0;
      sel      = 0;
      rst      = 1'b0;
      drive(1'b0, '0);

      // idle scan, no loads
      run(0, 72);

      // single load mid-frame
      add_load(5, 64'h8000_0000_0000_0000);
      run(0, 64);
      ld_cyc.delete(); ld_mat.delete();

      // double load, last wins
      add_load(3, 64'hFF00_0000_0000_0000);
      add_load(10, 64'h00FF_0000_0000_0000);
      run(0, 64);
      ld_cyc.delete(); ld_mat.delete();

      // load exactly in the boundary cycle
      add_load(31, 64'hC0C0_0000_0000_0000);
      run(0, 64);
      ld_cyc.delete(); ld_mat.delete();

      // reset mid-frame with a board pending
      add_load(5, 64'hAAAA_AAAA_AAAA_AAAA);
      run(0, 10);
      #2;
      rst = 1'b0;
      #1;
      check_reset("async_rst");
      ld_cyc.delete(); ld_mat.delete();
      run(0, 64);

      // wide blanking, full board then a mixed board
      add_load(0, 64'hFFFF_FFFF_FFFF_FFFF);
      add_load(40, 64'h0123_4567_89AB_CDEF);
      run(1, 96);
      ld_cyc.delete(); ld_mat.delete();

      check("sb_drained", 64'(exp_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
